// File: rtl/mux_feeder_pkg.sv
// rtl/mux_feeder_pkg.sv - shared state encoding, default width and select constants
package mux_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

endpackage

// File: rtl/operand_regfile.sv
// rtl/operand_regfile.sv - four operand registers with a write port that refuses the operand on display
module operand_regfile
    import mux_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             lock_en,
    input  logic [1:0]       lock_addr,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic             wr_err
);

    logic [WIDTH-1:0] reg_a, reg_b, reg_c, reg_d;
    logic             reject;

    // The operand currently presented to the consumer must stay stable.
    assign reject = wr_en && lock_en && (wr_addr == lock_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_c  <= '0;
            reg_d  <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= reject;
            if (wr_en && !reject) begin
                case (wr_addr)
                    SEL_A:   reg_a <= wr_data;
                    SEL_B:   reg_b <= wr_data;
                    SEL_C:   reg_c <= wr_data;
                    default: reg_d <= wr_data;
                endcase
            end
        end
    end

    assign op_a = reg_a;
    assign op_b = reg_b;
    assign op_c = reg_c;
    assign op_d = reg_d;

endmodule

// File: rtl/mux_operand_feeder.sv
// rtl/mux_operand_feeder.sv - operand source and select sequencer for the 4-input mux; MUX_OPERAND_FEEDER_WRAP_EN makes scans wrap
module mux_operand_feeder
    import mux_feeder_pkg::*;
#(
    parameter int          WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned LAST_SEL = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WrEn,
    input  logic [1:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             Start,
    input  logic             Mode,
    input  logic [1:0]       SelIn,
    input  logic             Ack,
    input  logic             Abort,
    output logic [WIDTH-1:0] InA,
    output logic [WIDTH-1:0] InB,
    output logic [WIDTH-1:0] InC,
    output logic [WIDTH-1:0] InD,
    output logic [1:0]       Sel,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic             WrErr
);

    localparam logic [1:0] LAST_IDX = 2'(LAST_SEL);

    state_t     state, state_n;
    logic [1:0] sel_q, sel_n;
    logic       scan_q, scan_n;
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
    logic       wrap_q, wrap_n;
`endif

    operand_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk       (Clk),
        .rst       (Rst),
        .wr_en     (WrEn),
        .wr_addr   (WrAddr),
        .wr_data   (WrData),
        .lock_en   (state == PRESENT),
        .lock_addr (sel_q),
        .op_a      (InA),
        .op_b      (InB),
        .op_c      (InC),
        .op_d      (InD),
        .wr_err    (WrErr)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            sel_q  <= SEL_A;
            scan_q <= 1'b0;
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
            wrap_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sel_q  <= sel_n;
            scan_q <= scan_n;
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
            wrap_q <= wrap_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        scan_n  = scan_q;
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
        wrap_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (Start) begin
                    scan_n  = Mode;
                    sel_n   = Mode ? SEL_A : SelIn;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                // Abort wins over a same-cycle Ack and suppresses Done.
                if (Abort) begin
                    state_n = IDLE;
                end else if (Ack) begin
                    if (!scan_q) begin
                        state_n = FINISH;
                    end else if (sel_q == LAST_IDX) begin
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
                        sel_n  = SEL_A;
                        wrap_n = 1'b1;
`else
                        state_n = FINISH;
`endif
                    end else begin
                        sel_n = sel_q + 2'd1;
                    end
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign Sel   = sel_q;
    assign Valid = (state == PRESENT);
    assign Busy  = (state != IDLE);
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
    assign Done  = (state == FINISH) || wrap_q;
`else
    assign Done  = (state == FINISH);
`endif

endmodule

// File: tb/tb_mux_operand_feeder.sv
// tb/tb_mux_operand_feeder.sv - directed self-checking bench for mux_operand_feeder
module tb_mux_operand_feeder;

    logic       Clk = 1'b0;
    logic       Rst, WrEn, Start, Mode, Ack, Abort;
    logic [1:0] WrAddr, SelIn;
    logic [7:0] WrData;
    logic [7:0] InA, InB, InC, InD;
    logic [1:0] Sel;
    logic       Valid, Busy, Done, WrErr;

    int checks = 0;
    int errors = 0;

    mux_operand_feeder #(.WIDTH(8), .LAST_SEL(3)) dut (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Start(Start), .Mode(Mode), .SelIn(SelIn), .Ack(Ack), .Abort(Abort),
        .InA(InA), .InB(InB), .InC(InC), .InD(InD), .Sel(Sel),
        .Valid(Valid), .Busy(Busy), .Done(Done), .WrErr(WrErr)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] s, input logic v,
                             input logic b, input logic d);
        check({tag, ".sel"},   32'(Sel),   32'(s));
        check({tag, ".valid"}, 32'(Valid), 32'(v));
        check({tag, ".busy"},  32'(Busy),  32'(b));
        check({tag, ".done"},  32'(Done),  32'(d));
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; WrEn = 1'b0; Start = 1'b0; Mode = 1'b0; Ack = 1'b0; Abort = 1'b0;
        WrAddr = 2'd0; SelIn = 2'd0; WrData = 8'h00;
        tick(); tick();
        Rst = 1'b0;
        check("rst.ina", 32'(InA), 32'h0);
        check("rst.ind", 32'(InD), 32'h0);
        check("rst.wrerr", 32'(WrErr), 32'h0);
        check_ctl("rst", 2'd0, 1'b0, 1'b0, 1'b0);

        write(2'd0, 8'h11); write(2'd1, 8'h22); write(2'd2, 8'h33); write(2'd3, 8'h44);
        check("wr.ina", 32'(InA), 32'h11);
        check("wr.inb", 32'(InB), 32'h22);
        check("wr.inc", 32'(InC), 32'h33);
        check("wr.ind", 32'(InD), 32'h44);

        // single select of operand C
        Start = 1'b1; Mode = 1'b0; SelIn = 2'd2;
        tick();
        Start = 1'b0;
        check_ctl("single.present", 2'd2, 1'b1, 1'b1, 1'b0);
        check("single.inc", 32'(InC), 32'h33);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_ctl("single.finish", 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        check_ctl("single.idle", 2'd2, 1'b0, 1'b0, 1'b0);

        // full scan with Ack held high; Ack in IDLE is ignored
        Start = 1'b1; Mode = 1'b1; Ack = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_ctl($sformatf("scan.step%0d", i), 2'(i), 1'b1, 1'b1, 1'b0);
            tick();
        end
`ifdef MUX_OPERAND_FEEDER_WRAP_EN
        check_ctl("scan.wrap", 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        check_ctl("scan.after_wrap", 2'd1, 1'b1, 1'b1, 1'b0);
        Ack = 1'b0; Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check_ctl("scan.abort", 2'd1, 1'b0, 1'b0, 1'b0);
`else
        check_ctl("scan.finish", 2'd3, 1'b0, 1'b1, 1'b1);
        Ack = 1'b0;
        tick();
        check_ctl("scan.idle", 2'd3, 1'b0, 1'b0, 1'b0);
`endif

        // scan stalled at Sel=1, plus writes while presenting
        Start = 1'b1; Mode = 1'b1;
        tick();
        Start = 1'b0;
        check_ctl("hold.start", 2'd0, 1'b1, 1'b1, 1'b0);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_ctl($sformatf("hold.wait%0d", i), 2'd1, 1'b1, 1'b1, 1'b0);
        end
        write(2'd1, 8'hAA);
        check("lock.wrerr", 32'(WrErr), 32'h1);
        check("lock.inb", 32'(InB), 32'h22);
        write(2'd3, 8'hBB);
        check("lock.wrerr_clear", 32'(WrErr), 32'h0);
        check("lock.ind", 32'(InD), 32'hBB);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_ctl("hold.advance", 2'd2, 1'b1, 1'b1, 1'b0);

        // abort beats ack
        Abort = 1'b1; Ack = 1'b1;
        tick();
        Abort = 1'b0; Ack = 1'b0;
        check_ctl("abort.idle", 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("abort.nodone", 2'd2, 1'b0, 1'b0, 1'b0);

        // Start while busy is ignored
        Start = 1'b1; Mode = 1'b1;
        tick();
        check_ctl("busy.start", 2'd0, 1'b1, 1'b1, 1'b0);
        Mode = 1'b0; SelIn = 2'd3;
        tick();
        Start = 1'b0;
        check_ctl("busy.ignore", 2'd0, 1'b1, 1'b1, 1'b0);
        Ack = 1'b1;
        tick();
        check_ctl("busy.still_scan", 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        Ack = 1'b0;
        check_ctl("reset.pre", 2'd2, 1'b1, 1'b1, 1'b0);

        // reset mid-scan, simultaneous write is discarded
        Rst = 1'b1; WrEn = 1'b1; WrAddr = 2'd0; WrData = 8'h5A;
        tick();
        Rst = 1'b0; WrEn = 1'b0;
        check("midrst.ina", 32'(InA), 32'h0);
        check("midrst.inc", 32'(InC), 32'h0);
        check("midrst.ind", 32'(InD), 32'h0);
        check_ctl("midrst", 2'd0, 1'b0, 1'b0, 1'b0);

        Start = 1'b1; Mode = 1'b0; SelIn = 2'd1;
        tick();
        Start = 1'b0;
        check_ctl("post.present", 2'd1, 1'b1, 1'b1, 1'b0);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check_ctl("post.finish", 2'd1, 1'b0, 1'b1, 1'b1);
        tick();
        check_ctl("post.idle", 2'd1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
